sdi_rx_timing_monitor: RTL

- Sits directly downstream of the SDI receiver core, on its receive clock.
- Consumes the receiver's timing flags (trs_out, hblank, vblank, ln1_out, vid_active) and error flags.
- Measures the active samples per line, the total lines per frame and the active lines per frame.
- Declares the format stable after consecutive identical frames and keeps saturating error counters for status registers / debug.

---
 rtl/sdi_rx_timing_monitor.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/sdi_rx_timing_monitor.sv
// SDI receive timing monitor: measures line/frame geometry from the receiver's
// timing flags, tracks format stability and keeps saturating error counters.
module sdi_rx_timing_monitor #(
    parameter int STABLE_FRAMES = 3,
    parameter int CNT_W         = 16,
    parameter int SPL_W         = 12
) (
    input  logic             rx_clk,
    input  logic             rstn,
    input  logic             vid_active,
    input  logic             trs_out,
    input  logic             hblank,
    input  logic             vblank,
    input  logic [10:0]      ln1_out,
    input  logic             eav_error,
    input  logic             sav_error,
    input  logic             y1_crc_error,
    input  logic             c1_crc_error,
    input  logic             clr_cnt,
    output logic [SPL_W-1:0] active_spl,
    output logic [10:0]      frame_lines,
    output logic [10:0]      active_lines,
    output logic             fmt_stable,
    output logic             fmt_change,
    output logic             frame_tick,
    output logic [CNT_W-1:0] crc_err_cnt,
    output logic [CNT_W-1:0] trs_err_cnt
);
    typedef enum logic [1:0] {SEEK, MEASURE, LOCKED} state_t;

    localparam logic [3:0] STABLE_N = 4'(STABLE_FRAMES);

    state_t           state, state_nx;
    logic [SPL_W-1:0] spl_cnt, spl_cnt_nx;
    logic [SPL_W-1:0] ref_spl, ref_spl_nx;
    logic             ref_vld, ref_vld_nx;
    logic             spl_mismatch, spl_mismatch_nx;
    logic [10:0]      line_cnt, line_cnt_nx;
    logic [10:0]      act_cnt, act_cnt_nx;
    logic [3:0]       match_cnt, match_cnt_nx, match_inc;

    logic [SPL_W-1:0] active_spl_nx;
    logic [10:0]      frame_lines_nx, active_lines_nx;
    logic             fmt_stable_nx, fmt_change_nx, frame_tick_nx;
    logic [CNT_W-1:0] crc_err_cnt_nx, trs_err_cnt_nx;

    logic             eav, boundary, sample, line_active;
    logic [10:0]      tot_lines, tot_act;
    logic [SPL_W-1:0] fin_ref;
    logic             fin_ref_vld, fin_mismatch, frame_match;

    function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] cnt,
                                                   input logic inc, input logic clr);
        if (clr)
            return '0;
        if (inc && (cnt != '1))
            return cnt + CNT_W'(1);
        return cnt;
    endfunction

    assign eav         = vid_active & trs_out & hblank;
    assign boundary    = eav & (ln1_out == 11'd1);
    assign sample      = vid_active & ~trs_out & ~hblank;
    assign line_active = ~vblank;

    // Running totals including the line closed by the current EAV, so the
    // boundary line is accounted to the frame it ends.
    always_comb begin
        tot_lines    = line_cnt + 11'd1;
        tot_act      = line_active ? act_cnt + 11'd1 : act_cnt;
        fin_ref      = ref_spl;
        fin_ref_vld  = ref_vld;
        fin_mismatch = spl_mismatch;
        if (line_active) begin
            if (ref_vld) begin
                fin_mismatch = spl_mismatch | (spl_cnt != ref_spl);
            end else begin
                fin_ref     = spl_cnt;
                fin_ref_vld = 1'b1;
            end
        end
        frame_match = ~fin_mismatch & (tot_lines == frame_lines) & (fin_ref == active_spl);
        match_inc   = match_cnt + 4'd1;
    end

    always_comb begin
        state_nx        = state;
        spl_cnt_nx      = spl_cnt;
        ref_spl_nx      = ref_spl;
        ref_vld_nx      = ref_vld;
        spl_mismatch_nx = spl_mismatch;
        line_cnt_nx     = line_cnt;
        act_cnt_nx      = act_cnt;
        match_cnt_nx    = match_cnt;
        active_spl_nx   = active_spl;
        frame_lines_nx  = frame_lines;
        active_lines_nx = active_lines;
        fmt_stable_nx   = fmt_stable;
        fmt_change_nx   = 1'b0;
        frame_tick_nx   = 1'b0;

        if (sample && (spl_cnt != '1))
            spl_cnt_nx = spl_cnt + SPL_W'(1);

        if (!vid_active) begin
            state_nx        = SEEK;
            spl_cnt_nx      = '0;
            ref_spl_nx      = '0;
            ref_vld_nx      = 1'b0;
            spl_mismatch_nx = 1'b0;
            line_cnt_nx     = '0;
            act_cnt_nx      = '0;
            match_cnt_nx    = '0;
            fmt_stable_nx   = 1'b0;
            fmt_change_nx   = (state == LOCKED);
        end else if (eav) begin
            spl_cnt_nx = '0;
            if (boundary) begin
                ref_spl_nx      = '0;
                ref_vld_nx      = 1'b0;
                spl_mismatch_nx = 1'b0;
                line_cnt_nx     = '0;
                act_cnt_nx      = '0;
                if (state == SEEK) begin
                    state_nx     = MEASURE;
                    match_cnt_nx = '0;
                end else begin
                    active_spl_nx   = fin_ref;
                    frame_lines_nx  = tot_lines;
                    active_lines_nx = tot_act;
                    frame_tick_nx   = 1'b1;
                    if (state == LOCKED) begin
                        if (!frame_match) begin
                            state_nx      = MEASURE;
                            fmt_stable_nx = 1'b0;
                            fmt_change_nx = 1'b1;
                            match_cnt_nx  = '0;
                        end
                    end else if (frame_match) begin
                        match_cnt_nx = match_inc;
                        if (match_inc == STABLE_N) begin
                            state_nx      = LOCKED;
                            fmt_stable_nx = 1'b1;
                        end
                    end else begin
                        match_cnt_nx = '0;
                    end
                end
            end else begin
                line_cnt_nx     = tot_lines;
                act_cnt_nx      = tot_act;
                ref_spl_nx      = fin_ref;
                ref_vld_nx      = fin_ref_vld;
                spl_mismatch_nx = fin_mismatch;
            end
        end
    end

    always_comb begin
        crc_err_cnt_nx = sat_count(crc_err_cnt, (y1_crc_error | c1_crc_error) & vid_active, clr_cnt);
        trs_err_cnt_nx = sat_count(trs_err_cnt, (eav_error | sav_error) & vid_active, clr_cnt);
    end

    always_ff @(posedge rx_clk) begin
        if (!rstn) begin
            state        <= SEEK;
            spl_cnt      <= '0;
            ref_spl      <= '0;
            ref_vld      <= 1'b0;
            spl_mismatch <= 1'b0;
            line_cnt     <= '0;
            act_cnt      <= '0;
            match_cnt    <= '0;
            active_spl   <= '0;
            frame_lines  <= '0;
            active_lines <= '0;
            fmt_stable   <= 1'b0;
            fmt_change   <= 1'b0;
            frame_tick   <= 1'b0;
            crc_err_cnt  <= '0;
            trs_err_cnt  <= '0;
        end else begin
            state        <= state_nx;
            spl_cnt      <= spl_cnt_nx;
            ref_spl      <= ref_spl_nx;
            ref_vld      <= ref_vld_nx;
            spl_mismatch <= spl_mismatch_nx;
            line_cnt     <= line_cnt_nx;
            act_cnt      <= act_cnt_nx;
            match_cnt    <= match_cnt_nx;
            active_spl   <= active_spl_nx;
            frame_lines  <= frame_lines_nx;
            active_lines <= active_lines_nx;
            fmt_stable   <= fmt_stable_nx;
            fmt_change   <= fmt_change_nx;
            frame_tick   <= frame_tick_nx;
            crc_err_cnt  <= crc_err_cnt_nx;
            trs_err_cnt  <= trs_err_cnt_nx;
        end
    end
endmodule
